// File: rtl/digit_count_pkg.sv
// Shared types for the digit-count scheduler: FSM states, word width and
// the per-word bit-class count record produced by the classifier.
package digit_count_pkg;

  localparam int WORD_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY   = 2'd1,
    RESULT = 2'd2
  } state_t;

  typedef struct packed {
    logic [2:0] ones;
    logic [2:0] zeros;
    logic [2:0] xz;
  } bit_counts_t;

endpackage

// File: rtl/digit_classifier.sv
// Combinational per-bit classifier: counts bits that are exactly 1, exactly 0,
// and anything else (X/Z, which only a 4-state simulator can present).
module digit_classifier
  import digit_count_pkg::*;
(
  input  logic [WORD_W-1:0] data,
  output bit_counts_t       counts
);

  always_comb begin
    counts = '0;
    for (int i = 0; i < WORD_W; i++) begin
      if (data[i] === 1'b1)
        counts.ones = counts.ones + 3'd1;
      else if (data[i] === 1'b0)
        counts.zeros = counts.zeros + 3'd1;
      else
        counts.xz = counts.xz + 3'd1;
    end
  end

endmodule

// File: rtl/digit_count_scheduler.sv
// Round-robin frame scheduler sharing one digit classifier between requesters
// A and B; accumulates saturating per-frame bit-class counts and returns a tagged result.
module digit_count_scheduler
  import digit_count_pkg::*;
#(
  parameter int ACC_W = 8
)
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_valid,
  input  logic [WORD_W-1:0] a_data,
  input  logic              a_last,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [WORD_W-1:0] b_data,
  input  logic              b_last,
  output logic              b_ready,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              res_id,
  output logic [ACC_W-1:0]  res_ones,
  output logic [ACC_W-1:0]  res_zeros,
  output logic [ACC_W-1:0]  res_xz,
  output logic [ACC_W-1:0]  res_words,
  output logic              res_sat
);

  state_t state_reg, state_next;
  logic   grant_reg, grant_next;
  logic   rr_reg, rr_next;
  logic   sat_reg;

  logic [WORD_W-1:0]      sel_data;
  logic                   sel_valid;
  logic                   sel_last;
  logic                   accept;
  bit_counts_t            counts;
  logic [2:0]             incr [4];
  logic [3:0]             sat_hit;
  logic [3:0][ACC_W-1:0]  acc_val;

  assign sel_data  = grant_reg ? b_data  : a_data;
  assign sel_valid = grant_reg ? b_valid : a_valid;
  assign sel_last  = grant_reg ? b_last  : a_last;
  assign accept    = (state_reg == BUSY) && sel_valid;

  digit_classifier u_classifier (
    .data   (sel_data),
    .counts (counts)
  );

  always_comb begin
    state_next = state_reg;
    grant_next = grant_reg;
    rr_next    = rr_reg;
    unique case (state_reg)
      IDLE: begin
        if (a_valid || b_valid) begin
          // On contention rr picks the winner; otherwise whoever is valid.
          grant_next = (a_valid && b_valid) ? rr_reg : b_valid;
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (accept && sel_last)
          state_next = RESULT;
      end
      RESULT: begin
        if (res_ready) begin
          rr_next    = ~grant_reg;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      grant_reg <= 1'b0;
      rr_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      grant_reg <= grant_next;
      rr_reg    <= rr_next;
    end
  end

  // Accumulator order: ones, zeros, xz, words (one per accepted word).
  assign incr[0] = counts.ones;
  assign incr[1] = counts.zeros;
  assign incr[2] = counts.xz;
  assign incr[3] = 3'd1;

  for (genvar gi = 0; gi < 4; gi++) begin : g_acc
    logic [ACC_W-1:0] acc_reg;
    logic [ACC_W:0]   sum;

    assign sum         = {1'b0, acc_reg} + {{(ACC_W-2){1'b0}}, incr[gi]};
    assign sat_hit[gi] = accept & sum[ACC_W];
    assign acc_val[gi] = acc_reg;

    always_ff @(posedge clk) begin
      if (!rst_n || state_reg == IDLE)
        acc_reg <= '0;
      else if (accept)
        acc_reg <= sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || state_reg == IDLE)
      sat_reg <= 1'b0;
    else if (|sat_hit)
      sat_reg <= 1'b1;
  end

  assign a_ready   = (state_reg == BUSY) && !grant_reg;
  assign b_ready   = (state_reg == BUSY) &&  grant_reg;
  assign res_valid = (state_reg == RESULT);
  assign res_id    = grant_reg;
  assign res_ones  = acc_val[0];
  assign res_zeros = acc_val[1];
  assign res_xz    = acc_val[2];
  assign res_words = acc_val[3];
  assign res_sat   = sat_reg;

endmodule

// File: tb/tb_digit_count_scheduler.sv
// Directed bench for digit_count_scheduler: table-driven single-requester frames
// plus hand-written contention, saturation and mid-frame reset sequences.
module tb_digit_count_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       a_valid, b_valid, a_last, b_last, res_ready;
  logic [3:0] a_data, b_data;

  logic       a_ready, b_ready, res_valid, res_id, res_sat;
  logic [7:0] res_ones, res_zeros, res_xz, res_words;

  logic       a_ready3, b_ready3, res_valid3, res_id3, res_sat3;
  logic [2:0] res_ones3, res_zeros3, res_xz3, res_words3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  digit_count_scheduler #(.ACC_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_data(a_data), .a_last(a_last), .a_ready(a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_last(b_last), .b_ready(b_ready),
    .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
    .res_ones(res_ones), .res_zeros(res_zeros), .res_xz(res_xz),
    .res_words(res_words), .res_sat(res_sat)
  );

  digit_count_scheduler #(.ACC_W(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_data(a_data), .a_last(a_last), .a_ready(a_ready3),
    .b_valid(b_valid), .b_data(b_data), .b_last(b_last), .b_ready(b_ready3),
    .res_valid(res_valid3), .res_ready(res_ready), .res_id(res_id3),
    .res_ones(res_ones3), .res_zeros(res_zeros3), .res_xz(res_xz3),
    .res_words(res_words3), .res_sat(res_sat3)
  );

  typedef struct {
    bit          who;
    int          n;
    logic [15:0] data;
    int          ones;
    int          zeros;
    int          xz;
    int          words;
  } vec_t;

  vec_t vecs [4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference classification of a word the bench itself drives.
  function automatic void classify(input logic [3:0] w, output int o, output int z, output int x);
    o = 0; z = 0; x = 0;
    for (int i = 0; i < 4; i++) begin
      if (w[i] === 1'b1) o++;
      else if (w[i] === 1'b0) z++;
      else x++;
    end
  endfunction

  task automatic drive(input bit who, input logic v, input logic [3:0] d, input logic l);
    if (who) begin
      b_valid = v; b_data = d; b_last = l;
    end else begin
      a_valid = v; a_data = d; a_last = l;
    end
  endtask

  // Streams n words from one requester; term selects whether the final word carries last.
  task automatic send_frame(input bit who, input int n, input logic [15:0] data, input bit term);
    logic rdy;
    int   waited;
    for (int i = 0; i < n; i++) begin
      drive(who, 1'b1, data[4*i +: 4], term && (i == n - 1));
      waited = 0;
      rdy = who ? b_ready : a_ready;
      while (!rdy && waited < 20) begin
        tick();
        waited++;
        rdy = who ? b_ready : a_ready;
      end
      check("ready_seen", rdy, 1);
      if (i == 0) check("grant_latency", waited, 1);
      else        check("throughput", waited, 0);
      tick();
    end
    drive(who, 1'b0, 4'h0, 1'b0);
  endtask

  task automatic wait_result();
    int n = 0;
    while (!res_valid && n < 30) begin
      tick();
      n++;
    end
    check("res_valid_seen", res_valid, 1);
  endtask

  task automatic expect_result(input string tag, input bit id, input int ones, input int zeros,
                               input int xz, input int words, input bit sat);
    wait_result();
    $display("frame %s: id=%0d ones=%0d zeros=%0d xz=%0d words=%0d sat=%0d",
             tag, res_id, res_ones, res_zeros, res_xz, res_words, res_sat);
    check({tag, "_id"},    res_id,    id);
    check({tag, "_ones"},  res_ones,  ones);
    check({tag, "_zeros"}, res_zeros, zeros);
    check({tag, "_xz"},    res_xz,    xz);
    check({tag, "_words"}, res_words, words);
    check({tag, "_sat"},   res_sat,   sat);
    res_ready = 1'b1;
    tick();
  endtask

  initial begin
    logic [3:0] xz_word;
    int mo, mz, mx;

    vecs[0] = '{who: 1'b0, n: 2, data: 16'h000B, ones: 3,  zeros: 5, xz: 0, words: 2};
    vecs[1] = '{who: 1'b1, n: 1, data: 16'h000C, ones: 2,  zeros: 2, xz: 0, words: 1};
    vecs[2] = '{who: 1'b0, n: 4, data: 16'h5FFF, ones: 14, zeros: 2, xz: 0, words: 4};
    vecs[3] = '{who: 1'b1, n: 3, data: 16'h0421, ones: 3,  zeros: 9, xz: 0, words: 3};

    rst_n = 1'b0; res_ready = 1'b1;
    a_valid = 1'b0; a_data = 4'h0; a_last = 1'b0;
    b_valid = 1'b0; b_data = 4'h0; b_last = 1'b0;
    repeat (2) tick();

    check("rst_a_ready",   a_ready,   0);
    check("rst_b_ready",   b_ready,   0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_sat",   res_sat,   0);
    check("rst_res_id",    res_id,    0);
    check("rst_ones",      res_ones,  0);
    check("rst_zeros",     res_zeros, 0);
    check("rst_xz",        res_xz,    0);
    check("rst_words",     res_words, 0);
    rst_n = 1'b1;

    for (int v = 0; v < 4; v++) begin
      send_frame(vecs[v].who, vecs[v].n, vecs[v].data, 1'b1);
      expect_result($sformatf("vec%0d", v), vecs[v].who, vecs[v].ones, vecs[v].zeros,
                    vecs[v].xz, vecs[v].words, 1'b0);
    end

    // A 4-state simulator yields 1/1/2; a 2-state one resolves X/Z to 0 before the DUT sees it.
    xz_word = 4'b1xz0;
    classify(xz_word, mo, mz, mx);
    send_frame(1'b1, 1, {12'h000, xz_word}, 1'b1);
    expect_result("xz", 1'b1, mo, mz, mx, 1, 1'b0);

    // Contention: both requesters hold one-word frames from reset.
    rst_n = 1'b0;
    res_ready = 1'b0;
    a_valid = 1'b1; a_data = 4'b0111; a_last = 1'b1;
    b_valid = 1'b1; b_data = 4'b0001; b_last = 1'b1;
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      int n = 0;
      while (!res_valid && n < 30) begin
        if (k == 0) check("contend_b_ready_held", b_ready, 0);
        tick();
        n++;
      end
      check("contend_res_valid", res_valid, 1);
      $display("frame contend%0d: id=%0d ones=%0d words=%0d", k, res_id, res_ones, res_words);
      check("contend_id",    res_id,    k % 2);
      check("contend_ones",  res_ones,  (k % 2) ? 1 : 3);
      check("contend_words", res_words, 1);
      if (k == 0) begin
        for (int h = 0; h < 5; h++) begin
          tick();
          check("hold_res_valid", res_valid, 1);
          check("hold_res_id",    res_id,    0);
          check("hold_res_ones",  res_ones,  3);
          check("hold_res_zeros", res_zeros, 1);
          check("hold_b_ready",   b_ready,   0);
        end
        res_ready = 1'b1;
      end
      tick();
    end
    drive(1'b0, 1'b0, 4'h0, 1'b0);
    drive(1'b1, 1'b0, 4'h0, 1'b0);

    // Saturation observed on the ACC_W=3 instance; the 8-bit one must not saturate.
    send_frame(1'b0, 3, 16'h0FFF, 1'b1);
    wait_result();
    $display("frame sat: id=%0d ones=%0d zeros=%0d words=%0d sat=%0d",
             res_id3, res_ones3, res_zeros3, res_words3, res_sat3);
    check("sat3_valid", res_valid3, 1);
    check("sat3_id",    res_id3,    0);
    check("sat3_ones",  res_ones3,  7);
    check("sat3_zeros", res_zeros3, 0);
    check("sat3_words", res_words3, 3);
    check("sat3_sat",   res_sat3,   1);
    check("sat8_ones",  res_ones,   12);
    check("sat8_sat",   res_sat,    0);
    tick();

    // Mid-frame reset: A streams two words without last, then reset aborts it.
    send_frame(1'b0, 2, 16'h00FF, 1'b0);
    check("midrst_busy_a_ready", a_ready, 1);
    rst_n = 1'b0;
    tick();
    check("midrst_res_valid", res_valid, 0);
    check("midrst_a_ready",   a_ready,   0);
    check("midrst_words",     res_words, 0);
    check("midrst_ones",      res_ones,  0);
    check("midrst_rr",        dut.rr_reg, 0);
    rst_n = 1'b1;
    send_frame(1'b1, 1, 16'h0001, 1'b1);
    expect_result("midrst_b", 1'b1, 1, 3, 0, 1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/digit_count_scheduler.md
# digit_count_scheduler

Frame-level scheduler that shares one 4-bit digit-classification datapath between two requesters (A and B). Each requester streams 4-bit words over valid/ready, with a last flag on the final word of a frame. The block grants the datapath one whole frame at a time, round-robin. It accumulates per-frame counts of 1, 0 and X/Z bits, and returns one result beat tagged with the requester id.

## Interface
- ACC_W, 8, width of every accumulator and of the word counter; minimum 3
- clk  in  1  rising-edge clock, the only clock
- rst_n  in  1  reset, synchronous, active-low
- a_valid / b_valid  in  1  requester word valid
- a_data / b_data  in  4  requester word; may carry X/Z in simulation
- a_last / b_last  in  1  marks the final word of a frame
- a_ready / b_ready  out  1  word accepted when valid && ready at the clock edge
- res_valid  out  1  result beat valid
- res_ready  in  1  downstream accepts the result
- res_id  out  1  0 = A, 1 = B
- res_ones / res_zeros / res_xz  out  ACC_W  per-frame bit counts
- res_words  out  ACC_W  number of words in the frame
- res_sat  out  1  at least one accumulator saturated during the frame

## Operation
- FSM states: IDLE, BUSY, RESULT.
- IDLE
  - All accumulators and res_sat are cleared.
  - If a_valid or b_valid is high: grant is registered and the FSM moves to BUSY.
  - If both are high, the requester selected by the round-robin pointer rr wins; rr = 0 favours A.
- BUSY
  - Only the granted requester sees ready = 1; the other requester's ready stays 0.
  - Each accepted word adds its per-bit class counts (0..4 each) to the accumulators; res_words increments by 1.
  - Accepting a word with last = 1 moves the FSM to RESULT.
  - A non-granted requester may hold valid indefinitely. Its word is not consumed and no ready is given.
- RESULT
  - res_valid = 1; the result fields are stable and are not modified.
  - On res_valid && res_ready: rr is set to the non-granted requester and the FSM returns to IDLE.
- Bit classification per bit, in simulation:
  - 1 when the bit is identically 1.
  - 0 when the bit is identically 0.
  - Otherwise the bit counts as X/Z.
  - ones + zeros + xz = 4 for every word.
  - Synthesized logic sees only 0/1, so its xz count is always 0.
- Arithmetic:
  - Every accumulator saturates at 2^ACC_W−1, never wraps.
  - Any saturation sets res_sat, which is sticky until IDLE.
- Reset (rst_n low at an edge, including mid-frame):
  - State goes to IDLE, rr goes to 0, accumulators are cleared.
  - Partial frames are discarded.
  - No result is produced for an aborted frame.
- Reset values: a_ready = b_ready = res_valid = res_sat = res_id = 0; all counts = 0.

## Timing
- Grant latency: valid seen in IDLE at edge t → BUSY at t+1 → ready high during cycle t+1. A word can first be accepted at edge t+1.
- Throughput in BUSY is 1 word per cycle while the granted requester holds valid.
- res_valid rises in the cycle after the last word is accepted. The counts include that last word.
- The minimum gap between frames is 2 cycles of ready = 0: the RESULT cycle (with res_ready = 1) plus the IDLE grant cycle.
- ready is a registered function of state and grant only. There is no combinational valid → ready path.
- res_valid does not depend combinationally on res_ready.

## Structure
- Package digit_count_pkg holds:
  - The state enum (IDLE, BUSY, RESULT).
  - The constant WORD_W = 4.
  - A struct holding the ones/zeros/xz counts as 3-bit fields.
- Sub-module digit_classifier: purely combinational, 4-bit word in, three 3-bit counts out, using case-equality per bit.
- The scheduler instantiates exactly one digit_classifier. Its input is muxed from the granted requester's data.

## Test plan
- A-only frame: A sends 4'b1011 then 4'b0000 (last) → ready is seen at t+1; result id = 0, ones = 3, zeros = 5, xz = 0, words = 2, sat = 0.
- X/Z classification: a single-word B frame 4'b1xz0 (last) → ones = 1, zeros = 1, xz = 2, words = 1, id = 1.
- Contention with back-pressure:
  - Setup: A and B are both valid from reset with one-word frames; res_ready is held low for 5 cycles after the first result.
  - Required: grant order is A, B, A, B.
  - Required: B's ready stays 0 until A's result is taken.
  - Required: res_valid and the result fields stay stable while res_ready is low.
- Saturation: ACC_W = 3; A sends three words of 4'b1111 → ones = 7, words = 3, res_sat = 1.
- Reset mid-frame:
  - Stimulus: A sends 2 words without last; rst_n is pulled low for 1 cycle; then B sends one word 4'b0001 (last).
  - Required: no result is produced for A.
  - Required: the B result is ones = 1, zeros = 3, words = 1, and rr = 0 after reset.
